// File: rtl/json_drive_framer.sv
// -----------------------------------------------------------------------------
// json_drive_framer
//
// Turns a signed fixed-point wheel command pair into the ASCII frame
//   {"T":<T_CODE>,"L":<ltext>,"R":<rtext>}\n
// and streams it one byte at a time to a uart_tx-style sink. Each value is
// clamped to +/-1.0 and printed as [-]d.ddd with FRAC_DIGITS fraction digits.
// The last accepted command can optionally be re-sent after REFRESH_CYCLES
// idle cycles as a keep-alive.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_left, cmd_right     two's complement speeds, units of 10^-FRAC_DIGITS
//   byte_data / byte_valid  outgoing ASCII byte
//   byte_ready              sink accepts byte_data on this edge
//   busy                    a frame is being converted or sent
//   frame_done              one-cycle pulse after the final '\n' is accepted
//   clamp_flag              sticky: some value was clamped since reset
//   frame_count             frames completed, wraps at 16 bits
// -----------------------------------------------------------------------------
module json_drive_framer #(
  parameter int VAL_W          = 12,
  parameter int FRAC_DIGITS    = 2,
  parameter int T_CODE         = 1,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [VAL_W-1:0] cmd_left,
  input  logic [VAL_W-1:0] cmd_right,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             clamp_flag,
  output logic [15:0]      frame_count
);

  localparam int SCALE     = 10 ** FRAC_DIGITS;
  localparam int TEXT_MAX  = 3 + FRAC_DIGITS;         // '-' + digit + '.' + fraction
  localparam int TLEN_W    = $clog2(TEXT_MAX + 1);
  localparam int FRAME_MAX = 18 + 2 * TEXT_MAX;
  localparam int LEN_W     = $clog2(FRAME_MAX + 1);
  localparam int CNT_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, SEND, DONE} state_t;

  // Printed value: txt[0] is the first character sent.
  typedef struct packed {
    logic [TEXT_MAX-1:0][7:0] txt;
    logic [TLEN_W-1:0]        len;
    logic                     clamped;
  } text_t;

  // Clamp to +/-SCALE and format as [-]d.fff, zero-padded fraction.
  function automatic text_t value_text(input logic signed [VAL_W-1:0] v);
    text_t t;
    int    val;
    int    mag;
    int    frac;
    int    p;
    t   = '0;
    val = int'(v);
    if (val > SCALE) begin
      val       = SCALE;
      t.clamped = 1'b1;
    end else if (val < -SCALE) begin
      val       = -SCALE;
      t.clamped = 1'b1;
    end
    mag = (val < 0) ? -val : val;
    p   = 0;
    if (val < 0) begin
      t.txt[p] = "-";
      p++;
    end
    t.txt[p] = (mag >= SCALE) ? "1" : "0";
    p++;
    t.txt[p] = ".";
    p++;
    frac = mag % SCALE;
    for (int k = FRAC_DIGITS - 1; k >= 0; k--) begin
      t.txt[p] = 8'(48 + (frac / (10 ** k)) % 10);
      p++;
    end
    t.len = TLEN_W'(p);
    return t;
  endfunction

  state_t                       state;
  logic signed [VAL_W-1:0]      l_cmd;
  logic signed [VAL_W-1:0]      r_cmd;
  logic                         have_cmd;
  logic [FRAME_MAX-1:0][7:0]    frame_buf;   // bytes still to send, next at [0]
  logic [LEN_W-1:0]             remain;      // bytes left including byte_data
  logic [CNT_W-1:0]             idle_cnt;
  logic                         refresh_hit;

  text_t                        l_txt;
  text_t                        r_txt;
  logic [FRAME_MAX-1:0][7:0]    frame_nxt;
  logic [LEN_W-1:0]             len_nxt;

  assign l_txt = value_text(l_cmd);
  assign r_txt = value_text(r_cmd);

  // Fires at the end of the REFRESH_CYCLES-th idle cycle after a frame.
  assign refresh_hit = (REFRESH_CYCLES > 0) && have_cmd &&
                       (idle_cnt == CNT_W'(REFRESH_CYCLES - 1));

  // Assemble the whole frame from the latched command; loaded in CONVERT.
  always_comb begin
    int p;
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    frame_nxt = '0;
    frame_nxt[0]  = "{";
    frame_nxt[1]  = "\"";
    frame_nxt[2]  = "T";
    frame_nxt[3]  = "\"";
    frame_nxt[4]  = ":";
    frame_nxt[5]  = 8'(48 + T_CODE);
    frame_nxt[6]  = ",";
    frame_nxt[7]  = "\"";
    frame_nxt[8]  = "L";
    frame_nxt[9]  = "\"";
    frame_nxt[10] = ":";
    p = 11;
    for (int i = 0; i < TEXT_MAX; i++) begin
      if (i < int'(l_txt.len)) begin
        frame_nxt[p] = l_txt.txt[i];
        p++;
      end
    end
    frame_nxt[p]     = ",";
    frame_nxt[p + 1] = "\"";
    frame_nxt[p + 2] = "R";
    frame_nxt[p + 3] = "\"";
    frame_nxt[p + 4] = ":";
    p = p + 5;
    for (int i = 0; i < TEXT_MAX; i++) begin
      if (i < int'(r_txt.len)) begin
        frame_nxt[p] = r_txt.txt[i];
        p++;
      end
    end
    frame_nxt[p]     = "}";
    frame_nxt[p + 1] = 8'h0a;
    len_nxt = LEN_W'(p + 2);
  end

  // NOTE: the datapath registers (stored command, frame buffer) are plain
  // flops, not a RAM, so they share the async reset with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      clamp_flag  <= 1'b0;
      frame_count <= 16'd0;
      l_cmd       <= '0;
      r_cmd       <= '0;
      have_cmd    <= 1'b0;
      frame_buf   <= '0;
      remain      <= '0;
      idle_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            // A new command beats a refresh expiring on the same edge.
            l_cmd     <= cmd_left;
            r_cmd     <= cmd_right;
            have_cmd  <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            idle_cnt  <= '0;
            state     <= CONVERT;
          end else if (refresh_hit) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            idle_cnt  <= '0;
            state     <= CONVERT;
          end else if (REFRESH_CYCLES > 0 && have_cmd) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        CONVERT: begin
          clamp_flag <= clamp_flag | l_txt.clamped | r_txt.clamped;
          byte_data  <= frame_nxt[0];
          frame_buf  <= frame_nxt >> 8;
          remain     <= len_nxt;
          byte_valid <= 1'b1;
          state      <= SEND;
        end

        SEND: begin
          if (byte_ready) begin
            if (remain == LEN_W'(1)) begin
              byte_valid  <= 1'b0;
              frame_done  <= 1'b1;
              busy        <= 1'b0;
              frame_count <= frame_count + 16'd1;
              state       <= DONE;
            end else begin
              byte_data <= frame_buf[0];
              frame_buf <= frame_buf >> 8;
              remain    <= remain - 1'b1;
            end
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          cmd_ready  <= 1'b1;
          idle_cnt   <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_json_drive_framer.sv
// -----------------------------------------------------------------------------
// Testbench for json_drive_framer (VAL_W=12, FRAC_DIGITS=2, T_CODE=1,
// REFRESH_CYCLES=1000). Directed commands with hand-written expected frames.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_json_drive_framer;

  localparam int VW = 12;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [VW-1:0] cmd_left;
  logic [VW-1:0] cmd_right;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          busy;
  logic          frame_done;
  logic          clamp_flag;
  logic [15:0]   frame_count;

  int checks;
  int errors;
  int exp_count;

  json_drive_framer #(
    .VAL_W(VW), .FRAC_DIGITS(2), .T_CODE(1), .REFRESH_CYCLES(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_left(cmd_left), .cmd_right(cmd_right),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .frame_done(frame_done), .clamp_flag(clamp_flag),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a command and hold it until the accepting edge has passed.
  // Returns one cycle into CONVERT.
  task automatic send_cmd(input int l, input int r);
    int n = 0;
    cmd_left  = VW'(l);
    cmd_right = VW'(r);
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (cmd_ready === 1'b1) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Drain one frame. Entered one cycle after the accepting edge; leaves in the
  // first IDLE cycle after the DONE cycle. lat = edges from accept to first
  // byte_valid; stable_err counts byte_data changes while stalled; ready_hi
  // counts cycles with cmd_ready high from entry through the DONE cycle.
  task automatic collect(input bit stall, output string s, output int lat,
                         output int stable_err, output int ready_hi,
                         output bit done_ok);
    logic [7:0] held;
    bit         stalled;
    bit         got_nl;
    int         cyc;
    s = ""; lat = -1; stable_err = 0; ready_hi = 0; done_ok = 1'b0;
    held = 8'h00; stalled = 1'b0; got_nl = 1'b0; cyc = 0;
    while (!got_nl && cyc < 400) begin
      byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cmd_ready === 1'b1) ready_hi++;
      if (byte_valid === 1'b1) begin
        if (lat < 0) lat = cyc + 1;
        if (stalled && byte_data !== held) stable_err++;
        if (byte_ready) begin
          s = $sformatf("%s%c", s, byte_data);
          stalled = 1'b0;
          if (byte_data == 8'h0a) got_nl = 1'b1;
        end else begin
          stalled = 1'b1;
          held    = byte_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    byte_ready = 1'b0;
    if (got_nl) begin
      done_ok = (frame_done === 1'b1) && (busy === 1'b0);
      if (cmd_ready === 1'b1) ready_hi++;
      @(posedge clk); #1;
      if (frame_done !== 1'b0) done_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h want 00", byte_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (clamp_flag !== 1'b0) begin errors++; $display("FAIL reset_clamp_flag: got %b want 0", clamp_flag); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge: got %b want 1", cmd_ready); end
    exp_count = 0;
  endtask

  task automatic test_basic();
    string exp = "{\"T\":1,\"L\":0.25,\"R\":0.25}\n";
    string got;
    int lat, se, rh;
    bit dk;
    send_cmd(25, 25);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept: got %b want 1", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_after_accept: got %b want 0", cmd_ready); end
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp) begin errors++; $display("FAIL basic_frame: got '%s' want '%s'", got, exp); end
    checks++; if (got.len() != 26) begin errors++; $display("FAIL basic_len: got %0d want 26", got.len()); end
    checks++; if (lat < 1 || lat > 16) begin errors++; $display("FAIL basic_latency: got %0d want 1..16", lat); end
    checks++; if (!dk) begin errors++; $display("FAIL basic_frame_done: got bad pulse want single cycle"); end
    checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL basic_frame_count: got %0d want %0d", frame_count, exp_count); end
    checks++; if (clamp_flag !== 1'b0) begin errors++; $display("FAIL basic_clamp_flag: got %b want 0", clamp_flag); end
  endtask

  task automatic test_patterns();
    int    l_tab[3] = '{-25, 0, 5};
    int    r_tab[3] = '{25, -100, 100};
    int    n_tab[3] = '{27, 27, 26};
    string e_tab[3] = '{"{\"T\":1,\"L\":-0.25,\"R\":0.25}\n",
                        "{\"T\":1,\"L\":0.00,\"R\":-1.00}\n",
                        "{\"T\":1,\"L\":0.05,\"R\":1.00}\n"};
    string got;
    int lat, se, rh;
    bit dk;
    for (int i = 0; i < 3; i++) begin
      send_cmd(l_tab[i], r_tab[i]);
      collect(1'b0, got, lat, se, rh, dk);
      exp_count++;
      checks++; if (got != e_tab[i]) begin errors++; $display("FAIL pattern%0d_frame: got '%s' want '%s'", i, got, e_tab[i]); end
      checks++; if (got.len() != n_tab[i]) begin errors++; $display("FAIL pattern%0d_len: got %0d want %0d", i, got.len(), n_tab[i]); end
      checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL pattern%0d_count: got %0d want %0d", i, frame_count, exp_count); end
    end
    checks++; if (clamp_flag !== 1'b0) begin errors++; $display("FAIL pattern_clamp_flag: got %b want 0", clamp_flag); end
  endtask

  task automatic test_clamp();
    string exp1 = "{\"T\":1,\"L\":1.00,\"R\":-1.00}\n";
    string exp2 = "{\"T\":1,\"L\":0.25,\"R\":0.25}\n";
    string got;
    int lat, se, rh;
    bit dk;
    send_cmd(150, -2048);
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp1) begin errors++; $display("FAIL clamp_frame: got '%s' want '%s'", got, exp1); end
    checks++; if (clamp_flag !== 1'b1) begin errors++; $display("FAIL clamp_flag_set: got %b want 1", clamp_flag); end
    send_cmd(25, 25);
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp2) begin errors++; $display("FAIL clamp_next_frame: got '%s' want '%s'", got, exp2); end
    checks++; if (clamp_flag !== 1'b1) begin errors++; $display("FAIL clamp_flag_sticky: got %b want 1", clamp_flag); end
  endtask

  task automatic test_stall();
    string exp = "{\"T\":1,\"L\":-1.00,\"R\":0.75}\n";
    string got;
    int lat, se, rh;
    bit dk;
    send_cmd(-100, 75);
    collect(1'b1, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp) begin errors++; $display("FAIL stall_frame: got '%s' want '%s'", got, exp); end
    checks++; if (se != 0) begin errors++; $display("FAIL stall_data_stable: got %0d changes want 0", se); end
    checks++; if (!dk) begin errors++; $display("FAIL stall_frame_done: got bad pulse want single cycle"); end
    checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL stall_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    string exp_a = "{\"T\":1,\"L\":1.00,\"R\":-0.05}\n";
    string exp_b = "{\"T\":1,\"L\":-0.01,\"R\":0.00}\n";
    string got;
    int lat, se, rh;
    bit dk;
    send_cmd(100, -5);
    // Second command waits on the port for the whole of frame A.
    cmd_left  = VW'(-1);
    cmd_right = VW'(0);
    cmd_valid = 1'b1;
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp_a) begin errors++; $display("FAIL b2b_frame_a: got '%s' want '%s'", got, exp_a); end
    checks++; if (rh != 0) begin errors++; $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", rh); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b want 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_b: got busy %b want 1", busy); end
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp_b) begin errors++; $display("FAIL b2b_frame_b: got '%s' want '%s'", got, exp_b); end
    checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_refresh();
    string exp = "{\"T\":1,\"L\":-0.25,\"R\":-0.25}\n";
    string got;
    int lat, se, rh, idle;
    bit dk;
    send_cmd(-25, -25);
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got.len() != 28) begin errors++; $display("FAIL refresh_first_len: got %0d want 28", got.len()); end
    // Now in the first idle cycle after frame_done; count idle cycles.
    idle = 0;
    while (busy !== 1'b1 && idle < 2000) begin
      @(posedge clk); #1;
      idle++;
    end
    checks++; if (idle != 1000) begin errors++; $display("FAIL refresh_idle_cycles: got %0d want 1000", idle); end
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp) begin errors++; $display("FAIL refresh_frame: got '%s' want '%s'", got, exp); end
    checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL refresh_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_reset_mid_frame();
    string exp = "{\"T\":1,\"L\":0.05,\"R\":1.00}\n";
    string got;
    int lat, se, rh, bad;
    bit dk;
    send_cmd(25, 25);
    byte_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL midrst_sending: got byte_valid %b want 1", byte_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL midrst_byte_valid: got %b want 0", byte_valid); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", frame_count); end
    checks++; if (clamp_flag !== 1'b0) begin errors++; $display("FAIL midrst_clamp: got %b want 0", clamp_flag); end
    byte_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = 0;
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || byte_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_refresh: got %0d active cycles want 0", bad); end
    send_cmd(5, 100);
    collect(1'b0, got, lat, se, rh, dk);
    exp_count++;
    checks++; if (got != exp) begin errors++; $display("FAIL midrst_new_frame: got '%s' want '%s'", got, exp); end
    checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL midrst_new_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_count  = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_left   = '0;
    cmd_right  = '0;
    byte_ready = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_clamp();
    test_stall();
    test_back_to_back();
    test_refresh();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
